// File: rtl/hack_mem_ctrl_pkg.sv
// Shared definitions for the Hack memory controller.
// Address map defaults, FSM state and region encodings.
package hack_mem_ctrl_pkg;

  localparam logic [14:0] SCREEN_BASE_DEF = 15'h4000;
  localparam logic [14:0] KBD_ADDR_DEF    = 15'h6000;
  localparam int          RAM_AW_DEF      = 14;
  localparam int          SCR_AW_DEF      = 13;

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_WRITE = 2'd1,
    ST_READ  = 2'd2,
    ST_WAIT  = 2'd3
  } state_e;

  typedef enum logic [1:0] {
    RG_RAM  = 2'd0,
    RG_SCR  = 2'd1,
    RG_KBD  = 2'd2,
    RG_NONE = 2'd3
  } region_e;

endpackage

// File: rtl/hack_mem_ctrl_addr_decode.sv
// Hack data-address decoder: 15-bit word address to region.
// Ports: addr_i (word address), region_o (RAM/SCR/KBD/NONE).
module hack_addr_decode
  import hack_mem_ctrl_pkg::*;
#(
  parameter logic [14:0] SCREEN_BASE = SCREEN_BASE_DEF,
  parameter logic [14:0] KBD_ADDR    = KBD_ADDR_DEF
) (
  input  logic [14:0] addr_i,
  output region_e     region_o
);

  logic lt_scr;
  logic lt_kbd;
  logic eq_kbd;

  assign lt_scr = addr_i < SCREEN_BASE;
  assign lt_kbd = addr_i < KBD_ADDR;
  assign eq_kbd = addr_i == KBD_ADDR;

  always_comb begin
    region_o = RG_NONE;
    unique case (1'b1)
      lt_scr:             region_o = RG_RAM;
      !lt_scr && lt_kbd:  region_o = RG_SCR;
      eq_kbd:             region_o = RG_KBD;
      default:            region_o = RG_NONE;
    endcase
  end

endmodule

// File: rtl/hack_mem_ctrl.sv
// Memory-side sequencer for the Hack cpu held bus.
// Ports: cpu side (pc, address_m, *_latch, hold, instruction, in_m),
// ROM/RAM/screen ports (1-cycle read latency), keyboard input.
module hack_mem_ctrl
  import hack_mem_ctrl_pkg::*;
#(
  parameter logic [14:0] SCREEN_BASE = SCREEN_BASE_DEF,
  parameter logic [14:0] KBD_ADDR    = KBD_ADDR_DEF,
  parameter int          RAM_AW      = RAM_AW_DEF,
  parameter int          SCR_AW      = SCR_AW_DEF
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [14:0]       pc,
  input  logic [14:0]       address_m,
  input  logic              write_m_latch,
  input  logic [14:0]       address_m_latch,
  input  logic [15:0]       out_m_latch,
  output logic              hold,
  output logic [15:0]       instruction,
  output logic [15:0]       in_m,
  output logic [14:0]       rom_addr,
  input  logic [15:0]       rom_rdata,
  output logic [RAM_AW-1:0] ram_addr,
  output logic [15:0]       ram_wdata,
  output logic              ram_we,
  input  logic [15:0]       ram_rdata,
  output logic [SCR_AW-1:0] scr_addr,
  output logic [15:0]       scr_wdata,
  output logic              scr_we,
  input  logic [15:0]       scr_rdata,
  input  logic [15:0]       keyboard
);

  state_e      state_q, state_d;
  region_e     wr_rg, rd_rg;
  region_e     rsel_q;
  logic [15:0] kbd_q;
  logic [15:0] instr_q;
  logic [15:0] in_m_q;
  logic [15:0] rd_data;
  logic        do_wr;
  logic        do_rd;

  hack_addr_decode #(
    .SCREEN_BASE(SCREEN_BASE),
    .KBD_ADDR   (KBD_ADDR)
  ) u_wr_dec (
    .addr_i  (address_m_latch),
    .region_o(wr_rg)
  );

  hack_addr_decode #(
    .SCREEN_BASE(SCREEN_BASE),
    .KBD_ADDR   (KBD_ADDR)
  ) u_rd_dec (
    .addr_i  (address_m),
    .region_o(rd_rg)
  );

  always_ff @(posedge clock) begin
    if (reset) state_q <= ST_READ;
    else       state_q <= state_d;
  end

  // The cpu latch is only valid one cycle after RUN, so the slot
  // after RUN commits the write if one is latched, otherwise it
  // serves as the read-issue cycle and skips straight to WAIT.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_RUN:   state_d = ST_WRITE;
      ST_WRITE: state_d = write_m_latch ? ST_READ : ST_WAIT;
      ST_READ:  state_d = ST_WAIT;
      ST_WAIT:  state_d = ST_RUN;
      default:  state_d = ST_READ;
    endcase
  end

  always_comb begin
    do_wr = (state_q == ST_WRITE) && write_m_latch && !reset;
    do_rd = (state_q == ST_READ) ||
            ((state_q == ST_WRITE) && !write_m_latch);
    hold      = state_q != ST_RUN;
    rom_addr  = pc;
    ram_we    = do_wr && (wr_rg == RG_RAM);
    scr_we    = do_wr && (wr_rg == RG_SCR);
    ram_wdata = out_m_latch;
    scr_wdata = out_m_latch;
    ram_addr  = do_wr ? address_m_latch[RAM_AW-1:0]
                      : address_m[RAM_AW-1:0];
    scr_addr  = do_wr ? address_m_latch[SCR_AW-1:0]
                      : address_m[SCR_AW-1:0];
  end

  always_comb begin
    rd_data = '0;
    unique case (rsel_q)
      RG_RAM:  rd_data = ram_rdata;
      RG_SCR:  rd_data = scr_rdata;
      RG_KBD:  rd_data = kbd_q;
      default: rd_data = '0;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      rsel_q  <= RG_NONE;
      kbd_q   <= '0;
      instr_q <= '0;
      in_m_q  <= '0;
    end else begin
      if (do_rd) begin
        rsel_q <= rd_rg;
        kbd_q  <= keyboard;
      end
      if (state_q == ST_WAIT) begin
        instr_q <= rom_rdata;
        in_m_q  <= rd_data;
      end
    end
  end

  assign instruction = instr_q;
  assign in_m        = in_m_q;

endmodule

// File: tb/tb_hack_mem_ctrl.sv
// Scoreboard bench for hack_mem_ctrl with ROM/RAM/screen models
// and a tiny cpu model for the @123; D=A; @456; AMD=D+1 program.
module tb_hack_mem_ctrl;

  logic        clock = 1'b0;
  logic        reset;
  logic [14:0] pc;
  logic [14:0] address_m;
  logic        write_m_latch;
  logic [14:0] address_m_latch;
  logic [15:0] out_m_latch;
  logic        hold;
  logic [15:0] instruction;
  logic [15:0] in_m;
  logic [14:0] rom_addr;
  logic [15:0] rom_rdata;
  logic [13:0] ram_addr;
  logic [15:0] ram_wdata;
  logic        ram_we;
  logic [15:0] ram_rdata;
  logic [12:0] scr_addr;
  logic [15:0] scr_wdata;
  logic        scr_we;
  logic [15:0] scr_rdata;
  logic [15:0] keyboard;

  hack_mem_ctrl dut (
    .clock          (clock),
    .reset          (reset),
    .pc             (pc),
    .address_m      (address_m),
    .write_m_latch  (write_m_latch),
    .address_m_latch(address_m_latch),
    .out_m_latch    (out_m_latch),
    .hold           (hold),
    .instruction    (instruction),
    .in_m           (in_m),
    .rom_addr       (rom_addr),
    .rom_rdata      (rom_rdata),
    .ram_addr       (ram_addr),
    .ram_wdata      (ram_wdata),
    .ram_we         (ram_we),
    .ram_rdata      (ram_rdata),
    .scr_addr       (scr_addr),
    .scr_wdata      (scr_wdata),
    .scr_we         (scr_we),
    .scr_rdata      (scr_rdata),
    .keyboard       (keyboard)
  );

  always #5 clock = ~clock;

  logic [15:0] rom     [32768];
  logic [15:0] ram_m   [16384];
  logic [15:0] scr_m   [8192];
  logic [15:0] ref_ram [16384];
  logic [15:0] ref_scr [8192];

  always @(posedge clock) rom_rdata <= rom[rom_addr];

  always @(posedge clock) begin
    if (ram_we) ram_m[ram_addr] <= ram_wdata;
    ram_rdata <= ram_m[ram_addr];
  end

  always @(posedge clock) begin
    if (scr_we) scr_m[scr_addr] <= scr_wdata;
    scr_rdata <= scr_m[scr_addr];
  end

  typedef struct {
    logic [15:0] ins;
    logic [15:0] inm;
  } exp_t;

  exp_t sb[$];
  int   n_chk  = 0;
  int   n_fail = 0;

  logic [14:0] cpu_pc;
  logic [15:0] cpu_a;
  logic [15:0] cpu_d;

  task automatic chk(input string tag, input logic [15:0] got,
                     input logic [15:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] ref_read(input logic [14:0] a);
    logic [15:0] v;
    if (a < 15'd16384)      v = ref_ram[a[13:0]];
    else if (a < 15'd24576) v = ref_scr[a[12:0]];
    else if (a == 15'd24576) v = keyboard;
    else                    v = 16'h0000;
    return v;
  endfunction

  // Runs from the current RUN cycle to the next one, checking hold
  // length, we pulses and the popped scoreboard entry.
  task automatic wait_run(input int exp_hc, input logic rst_wr,
                          input int e_rwe, input logic [13:0] e_ra,
                          input int e_swe, input logic [12:0] e_sa,
                          input logic [15:0] e_wd);
    int n, hc, rwe, swe;
    logic [13:0] ra;
    logic [12:0] sa;
    logic [15:0] rd, sd;
    exp_t e;
    n = 0; hc = 0; rwe = 0; swe = 0;
    ra = '0; sa = '0; rd = '0; sd = '0;
    do begin
      @(negedge clock);
      n++;
      if (rst_wr && n == 1) reset = 1'b1;
      if (rst_wr && n == 2) begin
        reset = 1'b0;
        chk("rst_instr", instruction, 16'h0000);
        chk("rst_in_m", in_m, 16'h0000);
      end
      #1;
      if (hold) hc++;
      if (ram_we) begin rwe++; ra = ram_addr; rd = ram_wdata; end
      if (scr_we) begin swe++; sa = scr_addr; sd = scr_wdata; end
      if (n == 2) write_m_latch = 1'b0;
    end while (hold && n < 12);
    chk("hold_cycles", 16'(hc), 16'(exp_hc));
    chk("ram_we_cnt", 16'(rwe), 16'(e_rwe));
    chk("scr_we_cnt", 16'(swe), 16'(e_swe));
    if (e_rwe == 1) begin
      chk("ram_addr", {2'b0, ra}, {2'b0, e_ra});
      chk("ram_wdata", rd, e_wd);
    end
    if (e_swe == 1) begin
      chk("scr_addr", {3'b0, sa}, {3'b0, e_sa});
      chk("scr_wdata", sd, e_wd);
    end
    if (sb.size() == 0) begin
      chk("sb_empty", 16'h0001, 16'h0000);
    end else begin
      e = sb.pop_front();
      chk("instruction", instruction, e.ins);
      chk("in_m", in_m, e.inm);
    end
  endtask

  // Called at a RUN cycle: present the next fetch and optional write.
  task automatic next_instr(input logic [14:0] npc,
                            input logic [14:0] na,
                            input logic wr, input logic [14:0] wa,
                            input logic [15:0] wd, input logic rst_wr);
    exp_t e;
    int   e_rwe, e_swe;
    pc = npc;
    address_m = na;
    write_m_latch = wr;
    address_m_latch = wa;
    out_m_latch = wd;
    e_rwe = 0;
    e_swe = 0;
    if (wr && !rst_wr) begin
      if (wa < 15'd16384) begin
        ref_ram[wa[13:0]] = wd;
        e_rwe = 1;
      end else if (wa < 15'd24576) begin
        ref_scr[wa[12:0]] = wd;
        e_swe = 1;
      end
    end
    e.ins = rom[npc];
    e.inm = ref_read(na);
    sb.push_back(e);
    wait_run(wr ? 3 : 2, rst_wr, e_rwe, wa[13:0], e_swe, wa[12:0], wd);
  endtask

  task automatic cpu_step();
    logic [15:0] ins, v;
    logic [14:0] wa;
    ins = rom[cpu_pc];
    if (!ins[15]) begin
      cpu_a = ins;
      next_instr(cpu_pc + 15'd1, cpu_a[14:0], 1'b0, '0, '0, 1'b0);
    end else if (ins == 16'hEC10) begin
      cpu_d = cpu_a;
      next_instr(cpu_pc + 15'd1, cpu_a[14:0], 1'b0, '0, '0, 1'b0);
    end else if (ins == 16'hE7F8) begin
      v = cpu_d + 16'd1;
      wa = cpu_a[14:0];
      cpu_a = v;
      cpu_d = v;
      next_instr(cpu_pc + 15'd1, v[14:0], 1'b1, wa, v, 1'b0);
    end else begin
      next_instr(cpu_pc + 15'd1, cpu_a[14:0], 1'b0, '0, '0, 1'b0);
    end
    cpu_pc = cpu_pc + 15'd1;
  endtask

  initial begin
    for (int i = 0; i < 32768; i++) rom[i] = 16'(i * 37 + 11);
    rom[0] = 16'h007B;
    rom[1] = 16'hEC10;
    rom[2] = 16'h01C8;
    rom[3] = 16'hE7F8;
    for (int i = 0; i < 16384; i++) begin
      ram_m[i]   = 16'(i) ^ 16'hA5A5;
      ref_ram[i] = 16'(i) ^ 16'hA5A5;
    end
    for (int i = 0; i < 8192; i++) begin
      scr_m[i]   = 16'(i) ^ 16'h3C3C;
      ref_scr[i] = 16'(i) ^ 16'h3C3C;
    end
    keyboard = 16'd75;
    reset = 1'b1;
    pc = '0;
    address_m = 15'd5;
    write_m_latch = 1'b0;
    address_m_latch = '0;
    out_m_latch = '0;

    repeat (2) @(negedge clock);
    chk("reset_hold", {15'b0, hold}, 16'h0001);
    chk("reset_instr", instruction, 16'h0000);
    chk("reset_in_m", in_m, 16'h0000);
    chk("reset_ram_we", {15'b0, ram_we}, 16'h0000);
    chk("reset_scr_we", {15'b0, scr_we}, 16'h0000);
    reset = 1'b0;
    begin
      exp_t e;
      e.ins = rom[0];
      e.inm = ref_read(15'd5);
      sb.push_back(e);
    end
    wait_run(1, 1'b0, 0, '0, 0, '0, '0);

    cpu_pc = '0;
    cpu_a = 16'd5;
    cpu_d = '0;
    repeat (4) cpu_step();
    chk("ram456_model", ram_m[456], 16'd124);

    next_instr(15'd100, 15'd16383, 1'b0, '0, '0, 1'b0);
    next_instr(15'd101, 15'd16384, 1'b0, '0, '0, 1'b0);
    next_instr(15'd102, 15'd24575, 1'b0, '0, '0, 1'b0);
    next_instr(15'd32767, 15'd24576, 1'b0, '0, '0, 1'b0);
    next_instr(15'd0, 15'd24577, 1'b0, '0, '0, 1'b0);
    next_instr(15'd1, 15'd0, 1'b0, '0, '0, 1'b0);

    next_instr(15'd200, 15'd456, 1'b1, 15'd456, 16'd124, 1'b0);
    next_instr(15'd201, 15'd456, 1'b1, 15'd456, 16'hBEEF, 1'b0);
    next_instr(15'd202, 15'd16384, 1'b1, 15'd16384, 16'hFFFF, 1'b0);
    next_instr(15'd203, 15'd24575, 1'b1, 15'd24575, 16'h1357, 1'b0);
    keyboard = 16'd75;
    next_instr(15'd204, 15'd24576, 1'b1, 15'd24576, 16'h2222, 1'b0);
    next_instr(15'd205, 15'd24577, 1'b1, 15'd24577, 16'h3333, 1'b0);
    keyboard = 16'h0041;
    next_instr(15'd206, 15'd24576, 1'b0, '0, '0, 1'b0);

    next_instr(15'd300, 15'd777, 1'b1, 15'd777, 16'hDEAD, 1'b1);
    next_instr(15'd301, 15'd777, 1'b0, '0, '0, 1'b0);
    next_instr(15'd302, 15'd16500, 1'b1, 15'd16500, 16'hCAFE, 1'b1);
    next_instr(15'd303, 15'd16500, 1'b0, '0, '0, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule
